// File: rtl/collision_scorer.sv
// Purpose: detects player/obstacle overlap per video frame and keeps score, best score and speed level.
// Latency: frame_tick 1 cycle after the vsync fall is sampled; start 3 edges after start_n is first sampled low.
// Backpressure: none; the block follows the pixel stream and every output is a register.
module collision_scorer #(
  parameter int H_ACTIVE     = 640,
  parameter int V_ACTIVE     = 480,
  parameter int HIT_CYCLES   = 4,
  parameter int SCORE_FRAMES = 60
) (
  input  logic       CLOCK_50,
  input  logic       reset,
  input  logic [9:0] next_x,
  input  logic [9:0] next_y,
  input  logic       vsync,
  input  logic       player_drawing,
  input  logic       obstacle_drawing,
  input  logic       start_n,
  output logic       game_over,
  output logic [6:0] score,
  output logic [6:0] max_score,
  output logic [2:0] level,
  output logic       frame_tick,
  output logic       collision
);

  localparam int            FW         = (SCORE_FRAMES > 1) ? $clog2(SCORE_FRAMES) : 1;
  localparam logic [FW-1:0] FRAME_LAST = FW'(SCORE_FRAMES - 1);
  localparam logic [9:0]    HIT_TH     = 10'(HIT_CYCLES);

  typedef enum logic [1:0] {IDLE, RUN, OVER} state_t;

  state_t        state;
  logic          sync1, sync2, sync3;
  logic [2:0]    warm;
  logic          vs_q;
  logic [9:0]    ovl_cnt;
  logic [FW-1:0] frame_cnt;
  logic [3:0]    units;
  logic          start_press;
  logic          start_game;
  logic          overlap;

  // warm[2] says sync3 holds a real post-reset sample, so a start_n held
  // low through reset never looks like a fresh press.
  assign start_press = warm[2] & sync3 & ~sync2;
  assign start_game  = start_press & (state != RUN);
  assign overlap     = player_drawing & obstacle_drawing &
                       ({1'b0, next_x} < 11'(H_ACTIVE)) &
                       ({1'b0, next_y} < 11'(V_ACTIVE));

  // Two-flop synchronizer for the button plus one flop for edge detection.
  always_ff @(posedge CLOCK_50 or negedge reset) begin
    if (!reset) begin
      sync1 <= 1'b1;
      sync2 <= 1'b1;
      sync3 <= 1'b1;
      warm  <= 3'b000;
    end else begin
      sync1 <= start_n;
      sync2 <= sync1;
      sync3 <= sync2;
      warm  <= {warm[1:0], 1'b1};
    end
  end

  // Frame boundary: registered pulse on the first low sample of vsync.
  always_ff @(posedge CLOCK_50 or negedge reset) begin
    if (!reset) begin
      vs_q       <= 1'b1;
      frame_tick <= 1'b0;
    end else begin
      vs_q       <= vsync;
      frame_tick <= vs_q & ~vsync;
    end
  end

  // Saturating overlap counter; the tick cycle itself never counts.
  always_ff @(posedge CLOCK_50 or negedge reset) begin
    if (!reset) begin
      ovl_cnt <= '0;
    end else if (frame_tick || start_game) begin
      ovl_cnt <= '0;
    end else if (overlap && (ovl_cnt != 10'd1023)) begin
      ovl_cnt <= ovl_cnt + 10'd1;
    end
  end

  // Game FSM with score, level and best-score bookkeeping.
  always_ff @(posedge CLOCK_50 or negedge reset) begin
    if (!reset) begin
      state     <= IDLE;
      game_over <= 1'b1;
      collision <= 1'b0;
      score     <= '0;
      max_score <= '0;
      level     <= '0;
      frame_cnt <= '0;
      units     <= '0;
    end else begin
      collision <= 1'b0;
      unique case (state)
        IDLE, OVER: begin
          if (start_press) begin
            state     <= RUN;
            game_over <= 1'b0;
            score     <= '0;
            level     <= '0;
            frame_cnt <= '0;
            units     <= '0;
          end
        end
        RUN: begin
          if (frame_tick) begin
            if (ovl_cnt >= HIT_TH) begin
              // A hit beats any score increment due on the same tick.
              state     <= OVER;
              game_over <= 1'b1;
              collision <= 1'b1;
              if (score > max_score) max_score <= score;
            end else if (frame_cnt == FRAME_LAST) begin
              frame_cnt <= '0;
              if (score != 7'd99) begin
                score <= score + 7'd1;
                if (units == 4'd9) begin
                  units <= '0;
                  if (level != 3'd7) level <= level + 3'd1;
                end else begin
                  units <= units + 4'd1;
                end
              end
            end else begin
              frame_cnt <= frame_cnt + FW'(1);
            end
          end
        end
        default: begin
          state     <= IDLE;
          game_over <= 1'b1;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_collision_scorer.sv
// Purpose: self-checking bench for collision_scorer with a frame-level reference model.
// Latency: outputs compared every cycle on the falling clock edge.
// Backpressure: none; stimulus is directed frames and button presses.
module tb_collision_scorer;

  localparam int HIT = 4;
  localparam int SF  = 60;

  logic       clk = 1'b0;
  logic       rst;
  logic [9:0] nx, ny;
  logic       vs, pd, od, start_n;
  logic       go, ft, col;
  logic [6:0] score, max_score;
  logic [2:0] level;

  collision_scorer dut (
    .CLOCK_50        (clk),
    .reset           (rst),
    .next_x          (nx),
    .next_y          (ny),
    .vsync           (vs),
    .player_drawing  (pd),
    .obstacle_drawing(od),
    .start_n         (start_n),
    .game_over       (go),
    .score           (score),
    .max_score       (max_score),
    .level           (level),
    .frame_tick      (ft),
    .collision       (col)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;
  int col_cnt  = 0;
  int tick_cnt = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // Reference model: game state, survived frames and overlap count since the last tick.
  int m_state;   // 0 idle, 1 running, 2 over
  int surv, ovl, ecnt;
  int e_score, e_max, e_level, e_go, e_ft, e_col;
  bit h1, h2, h3, vprev, press, ov, tick, start;

  initial forever begin
    @(posedge clk or negedge rst);
    if (!rst) begin
      m_state = 0; surv = 0; ovl = 0; ecnt = 0;
      e_score = 0; e_max = 0; e_level = 0; e_go = 1; e_ft = 0; e_col = 0;
      h1 = 1; h2 = 1; h3 = 1; vprev = 1;
    end else begin
      // A press needs a high then low synchronized sample, both taken after reset.
      press = (ecnt >= 3) && h3 && !h2;
      tick  = (e_ft != 0);
      ov    = pd && od && (nx < 640) && (ny < 480);
      start = press && (m_state != 1);
      e_col = 0;
      if (start) begin
        m_state = 1;
        surv    = 0;
      end else if (m_state == 1 && tick) begin
        if (ovl >= HIT) begin
          m_state = 2;
          e_col   = 1;
          if (e_score > e_max) e_max = e_score;
        end else begin
          surv++;
        end
      end
      if (start || tick) ovl = 0;
      else if (ov && ovl < 1023) ovl++;
      e_score = (surv / SF > 99) ? 99 : surv / SF;
      e_level = (e_score / 10 > 7) ? 7 : e_score / 10;
      e_go    = (m_state != 1) ? 1 : 0;
      e_ft    = (vprev && !vs) ? 1 : 0;
      vprev   = vs;
      h3 = h2; h2 = h1; h1 = start_n;
      if (ecnt < 10) ecnt++;
    end
  end

  // Every-cycle comparison of all outputs against the model.
  initial forever begin
    @(negedge clk);
    check("m_game_over", go, e_go);
    check("m_score", score, e_score);
    check("m_max_score", max_score, e_max);
    check("m_level", level, e_level);
    check("m_frame_tick", ft, e_ft);
    check("m_collision", col, e_col);
    if (col === 1'b1) col_cnt++;
    if (ft === 1'b1) tick_cnt++;
  end

  // One frame: vsync low for 2 cycles (second one is the tick cycle), then
  // n overlap cycles at (x,y), then 2 quiet cycles.
  task automatic frame(input int n, input logic [9:0] x, input logic [9:0] y, input bit tick_ovl);
    vs = 1'b0; pd = 1'b0; od = 1'b0;
    @(negedge clk);
    if (tick_ovl) begin pd = 1'b1; od = 1'b1; nx = 10'd100; ny = 10'd200; end
    @(negedge clk);
    vs = 1'b1; pd = 1'b0; od = 1'b0;
    for (int i = 0; i < n; i++) begin
      pd = 1'b1; od = 1'b1; nx = x; ny = y;
      @(negedge clk);
    end
    pd = 1'b0; od = 1'b0; nx = 10'd0; ny = 10'd0;
    repeat (2) @(negedge clk);
  endtask

  // Hold start_n low for 4 cycles; game_over must fall within that window.
  task automatic press_start(input string name);
    bit seen;
    seen = 0;
    start_n = 1'b0;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      if (go === 1'b0) seen = 1;
    end
    start_n = 1'b1;
    check(name, seen, 1);
    repeat (3) @(negedge clk);
  endtask

  // Drop reset between clock edges and check outputs before any edge arrives.
  task automatic async_reset(input string name);
    @(negedge clk);
    #2 rst = 1'b0;
    #1;
    check({name, "_go"}, go, 1);
    check({name, "_score"}, score, 0);
    check({name, "_max"}, max_score, 0);
    check({name, "_level"}, level, 0);
    check({name, "_ft"}, ft, 0);
    check({name, "_col"}, col, 0);
    @(negedge clk);
    rst = 1'b1;
    repeat (4) @(negedge clk);
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1; vs = 1'b1; pd = 1'b0; od = 1'b0; nx = 10'd0; ny = 10'd0; start_n = 1'b0;
    #1 rst = 1'b0;
    repeat (3) @(negedge clk);
    check("rst_go", go, 1);
    check("rst_score", score, 0);
    check("rst_max", max_score, 0);
    check("rst_level", level, 0);

    // Button held low across reset release must not start the game.
    rst = 1'b1;
    repeat (10) @(negedge clk);
    check("held_low_no_start", go, 1);
    start_n = 1'b1;
    repeat (4) @(negedge clk);

    press_start("start_latency");
    check("start_score", score, 0);
    check("start_level", level, 0);

    // 600 clean frames.
    tick_cnt = 0; col_cnt = 0;
    repeat (600) frame(0, 10'd0, 10'd0, 0);
    check("ticks_600", tick_cnt, 600);
    check("score_600", score, 10);
    check("level_600", level, 1);
    check("no_col_600", col_cnt, 0);

    // Press while running is ignored.
    start_n = 1'b0; repeat (4) @(negedge clk);
    start_n = 1'b1; repeat (4) @(negedge clk);
    check("run_press_ignored", go, 0);

    // 3 overlaps: no hit; 4 overlaps: hit at the following tick.
    frame(3, 10'd100, 10'd200, 0);
    frame(4, 10'd100, 10'd200, 0);
    check("three_no_hit", col_cnt, 0);
    frame(0, 10'd0, 10'd0, 0);
    check("hit_col", col_cnt, 1);
    check("hit_go", go, 1);
    check("hit_max", max_score, 10);
    check("hit_score", score, 10);

    // Blanking overlaps and tick-cycle overlaps never count.
    press_start("restart1");
    col_cnt = 0;
    frame(4, 10'd700, 10'd200, 0);
    frame(4, 10'd100, 10'd500, 0);
    frame(3, 10'd100, 10'd200, 1);
    frame(3, 10'd100, 10'd200, 1);
    frame(0, 10'd0, 10'd0, 0);
    check("blank_tick_no_col", col_cnt, 0);
    check("blank_tick_go", go, 0);

    async_reset("rst_mid_run");

    // Hit lands on the tick that would have made score 10.
    press_start("start_race");
    col_cnt = 0;
    repeat (598) frame(0, 10'd0, 10'd0, 0);
    frame(4, 10'd100, 10'd200, 0);
    check("race_pre_score", score, 9);
    frame(0, 10'd0, 10'd0, 0);
    check("race_col", col_cnt, 1);
    check("race_score", score, 9);
    check("race_max", max_score, 9);
    check("race_go", go, 1);
    press_start("restart2");
    check("restart2_score", score, 0);
    check("restart2_max", max_score, 9);

    // Long run saturates score and level.
    repeat (6000) frame(0, 10'd0, 10'd0, 0);
    check("sat_score", score, 99);
    check("sat_level", level, 7);
    async_reset("rst_sat");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
